// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV64 instruction fetch stage.
package rv_fetch_pkg;

   localparam int unsigned XLEN      = 64;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] HALT_WORD = 32'h0000_0000;

   // Contents of the IF/ID pipeline register.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } if_id_t;

   // Fetch control: either issuing words or parked until a redirect.
   typedef enum logic {
      FETCH_RUN,
      FETCH_HALT
   } fetch_state_e;

   // Empty IF/ID slot: invalid, PC zero, NOP encoding.
   function automatic if_id_t if_id_bubble();
      if_id_t b;
      b.valid = 1'b0;
      b.pc    = '0;
      b.instr = NOP_INSTR;
      return b;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush (bubble) > stall (hold) > load > bubble.
module if_id_reg
   import rv_fetch_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   stall,
   input  logic   flush,
   input  logic   load,
   input  if_id_t din,
   output if_id_t q
);

   if_id_t slot_q, slot_d;

   // Select the next register contents.
   always_comb begin
      slot_d = slot_q;
      if (flush) begin
         slot_d = if_id_bubble();
      end else if (stall) begin
         slot_d = slot_q;
      end else if (load) begin
         slot_d = din;
      end else begin
         slot_d = if_id_bubble();
      end
   end

   // Register with synchronous reset to a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q <= if_id_bubble();
      end else begin
         slot_q <= slot_d;
      end
   end

   assign q = slot_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC, halt and redirect control for the fetch stage; feeds the IF/ID register.
module instruction_fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter int unsigned     XLEN      = 64,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int unsigned     MEM_BYTES = 160
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic [XLEN-1:0] Inst_address,
   input  logic [31:0]     Instruction,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_instr,
   output logic            halted,
   output logic            misalign_err,
   output logic [31:0]     fetch_count
);

   localparam int unsigned     PKG_XLEN = rv_fetch_pkg::XLEN;
   localparam logic [XLEN-1:0] LAST_PC  = XLEN'(MEM_BYTES - 32'd4);

   logic [XLEN-1:0] pc_q, pc_d;
   fetch_state_e    state_q, state_d;
   logic            misalign_q, misalign_d;
   logic [31:0]     count_q, count_d;
   logic            load;
   if_id_t          slot_din, slot;

   // Per-edge priority: redirect > stall > halted > flush > end-of-program > fetch.
   always_comb begin
      pc_d       = pc_q;
      state_d    = state_q;
      misalign_d = misalign_q;
      count_d    = count_q;
      load       = 1'b0;
      if (redirect_valid) begin
         if (redirect_target[1:0] == 2'b00) begin
            pc_d    = redirect_target;
            state_d = FETCH_RUN;
         end else begin
            misalign_d = 1'b1;
            state_d    = FETCH_HALT;
         end
      end else if (stall) begin
         pc_d = pc_q;
      end else if (state_q == FETCH_HALT) begin
         pc_d = pc_q;
      end else if (flush) begin
         pc_d = pc_q + XLEN'(4);
      end else if ((Instruction == HALT_WORD) || (pc_q > LAST_PC)) begin
         state_d = FETCH_HALT;
      end else begin
         pc_d    = pc_q + XLEN'(4);
         count_d = count_q + 32'd1;
         load    = 1'b1;
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         state_q    <= FETCH_RUN;
         misalign_q <= 1'b0;
         count_q    <= '0;
      end else begin
         pc_q       <= pc_d;
         state_q    <= state_d;
         misalign_q <= misalign_d;
         count_q    <= count_d;
      end
   end

   // A redirect always leaves a bubble, so it is folded into the register's flush.
   always_comb begin
      slot_din.valid = 1'b1;
      slot_din.pc    = PKG_XLEN'(pc_q);
      slot_din.instr = Instruction;
   end

   if_id_reg u_if_id_reg (
      .clk   (clk),
      .reset (reset),
      .stall (stall),
      .flush (redirect_valid | flush),
      .load  (load),
      .din   (slot_din),
      .q     (slot)
   );

   assign Inst_address = pc_q;
   assign if_id_valid  = slot.valid;
   assign if_id_pc     = XLEN'(slot.pc);
   assign if_id_instr  = slot.instr;
   assign halted       = (state_q == FETCH_HALT);
   assign misalign_err = misalign_q;
   assign fetch_count  = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed plus randomized bench for instruction_fetch_unit with a reference model.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_target = '0;
   logic [63:0] Inst_address;
   logic [31:0] Instruction;
   logic        if_id_valid;
   logic [63:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        halted;
   logic        misalign_err;
   logic [31:0] fetch_count;

   logic [31:0] mem [0:39];

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   logic [63:0] m_pc;
   logic        m_halt;
   logic        m_mis;
   logic [31:0] m_cnt;
   logic        m_v;
   logic [63:0] m_ipc;
   logic [31:0] m_instr;

   instruction_fetch_unit #(
      .XLEN      (64),
      .RESET_PC  (64'h0),
      .MEM_BYTES (160)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .flush           (flush),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .Inst_address    (Inst_address),
      .Instruction     (Instruction),
      .if_id_valid     (if_id_valid),
      .if_id_pc        (if_id_pc),
      .if_id_instr     (if_id_instr),
      .halted          (halted),
      .misalign_err    (misalign_err),
      .fetch_count     (fetch_count)
   );

   always #5 clk = ~clk;

   // Combinational instruction memory; beyond its end it returns a NOP word
   always_comb begin
      if ($isunknown(Inst_address))
         Instruction = 32'h0;
      else if (Inst_address < 64'd160)
         Instruction = mem[Inst_address[7:2]];
      else
         Instruction = 32'h0000_0013;
   end

   function automatic logic [31:0] model_word(input logic [63:0] a);
      if (a < 64'd160) return mem[a[7:2]];
      return 32'h0000_0013;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_bubble();
      m_v     = 1'b0;
      m_ipc   = 64'h0;
      m_instr = 32'h0000_0013;
   endtask

   // Next model state from the current one and this cycle's inputs
   task automatic model_update(input logic r, input logic s, input logic f,
                               input logic rv, input logic [63:0] rt);
      logic [31:0] w;
      w = model_word(m_pc);
      if (r) begin
         m_pc = 64'h0; m_halt = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
         model_bubble();
      end else if (rv) begin
         if (rt[1:0] == 2'b00) begin
            m_pc = rt; m_halt = 1'b0;
         end else begin
            m_mis = 1'b1; m_halt = 1'b1;
         end
         model_bubble();
      end else if (s) begin
         if (f) model_bubble();
      end else if (m_halt) begin
         model_bubble();
      end else if (f) begin
         m_pc = m_pc + 64'd4;
         model_bubble();
      end else if (w == 32'h0 || m_pc > 64'd156) begin
         m_halt = 1'b1;
         model_bubble();
      end else begin
         m_v = 1'b1; m_ipc = m_pc; m_instr = w;
         m_pc = m_pc + 64'd4;
         m_cnt = m_cnt + 32'd1;
      end
   endtask

   task automatic check_all();
      chk("inst_address", Inst_address, m_pc);
      chk("if_id_valid", {63'h0, if_id_valid}, {63'h0, m_v});
      chk("if_id_pc", if_id_pc, m_ipc);
      chk("if_id_instr", {32'h0, if_id_instr}, {32'h0, m_instr});
      chk("halted", {63'h0, halted}, {63'h0, m_halt});
      chk("misalign_err", {63'h0, misalign_err}, {63'h0, m_mis});
      chk("fetch_count", {32'h0, fetch_count}, {32'h0, m_cnt});
   endtask

   task automatic step(input logic r, input logic s, input logic f,
                       input logic rv, input logic [63:0] rt);
      reset = r; stall = s; flush = f; redirect_valid = rv; redirect_target = rt;
      model_update(r, s, f, rv, rt);
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int unsigned i = 0; i < 40; i++) mem[i] = 32'h0000_0093 | (i << 15);
      mem[0]  = 32'h0021_0493;
      mem[1]  = 32'h0051_8233;
      mem[2]  = 32'h0000_0413;
      mem[3]  = 32'h0005_0513;
      mem[36] = 32'h0;

      @(negedge clk);
      step(1, 0, 0, 0, 64'h0);
      chk("rst_addr", Inst_address, 64'h0);
      chk("rst_instr", {32'h0, if_id_instr}, 64'h13);

      // Free-running fetch with a 2-cycle stall at pc 8
      step(0, 0, 0, 0, 64'h0);
      step(0, 0, 0, 0, 64'h0);
      step(0, 1, 0, 0, 64'h0);
      step(0, 1, 0, 0, 64'h0);
      chk("stall_addr", Inst_address, 64'h8);
      chk("stall_pc", if_id_pc, 64'h4);
      chk("stall_instr", {32'h0, if_id_instr}, 64'h0051_8233);
      chk("stall_count", {32'h0, fetch_count}, 64'd2);
      step(0, 0, 0, 0, 64'h0);
      step(0, 0, 0, 0, 64'h0);
      chk("run_pc", if_id_pc, 64'hC);
      chk("run_instr", {32'h0, if_id_instr}, 64'h0005_0513);
      chk("run_count", {32'h0, fetch_count}, 64'd4);

      // Redirect beats stall
      step(0, 1, 0, 1, 64'h40);
      chk("redir_addr", Inst_address, 64'h40);
      chk("redir_valid", {63'h0, if_id_valid}, 64'h0);
      step(0, 0, 0, 0, 64'h0);
      chk("redir_ifpc", if_id_pc, 64'h40);

      // Misaligned target, then aligned recovery
      step(0, 0, 0, 1, 64'h42);
      chk("mis_err", {63'h0, misalign_err}, 64'h1);
      chk("mis_halt", {63'h0, halted}, 64'h1);
      step(0, 0, 0, 0, 64'h0);
      step(0, 0, 0, 1, 64'h10);
      chk("mis_sticky", {63'h0, misalign_err}, 64'h1);
      chk("mis_unhalt", {63'h0, halted}, 64'h0);
      step(0, 0, 0, 0, 64'h0);
      chk("mis_resume", if_id_pc, 64'h10);

      // Run to the zero word at 0x90
      for (int i = 0; i < 64 && m_pc != 64'h90; i++) step(0, 0, 0, 0, 64'h0);
      chk("reach_90", Inst_address, 64'h90);
      step(0, 0, 0, 0, 64'h0);
      step(0, 0, 0, 0, 64'h0);
      chk("end_halt", {63'h0, halted}, 64'h1);
      chk("end_hold", Inst_address, 64'h90);
      step(0, 0, 0, 1, 64'h24);
      step(0, 0, 0, 0, 64'h0);
      chk("end_resume", if_id_pc, 64'h24);

      // Range end: 0x9C is legal, 0xA0 is past the memory
      mem[36] = 32'h0010_0093;
      step(0, 0, 0, 1, 64'h9C);
      step(0, 0, 0, 0, 64'h0);
      step(0, 0, 0, 0, 64'h0);
      chk("range_halt", {63'h0, halted}, 64'h1);
      chk("range_hold", Inst_address, 64'hA0);

      // Flush alone advances pc without counting; stall+flush holds pc
      step(0, 0, 0, 1, 64'h20);
      step(0, 0, 0, 0, 64'h0);
      step(0, 0, 1, 0, 64'h0);
      chk("flush_addr", Inst_address, 64'h28);
      step(0, 1, 1, 0, 64'h0);
      chk("sflush_addr", Inst_address, 64'h28);

      // Randomized traffic against the model
      mem[20] = 32'h0;
      for (int i = 0; i < 400; i++) begin
         logic        r, s, f, rv;
         logic [63:0] t;
         r  = ($urandom_range(0, 99) == 0);
         s  = ($urandom_range(0, 3) == 0);
         f  = ($urandom_range(0, 4) == 0);
         rv = ($urandom_range(0, 7) == 0);
         t  = 64'($urandom_range(0, 41)) * 64'd4;
         if ($urandom_range(0, 5) == 0) t = t + 64'($urandom_range(1, 3));
         step(r, s, f, rv, t);
      end

      // Reset while running at 0x30 with a valid IF/ID
      step(0, 0, 0, 1, 64'h2C);
      step(0, 0, 0, 0, 64'h0);
      chk("pre_rst_addr", Inst_address, 64'h30);
      chk("pre_rst_valid", {63'h0, if_id_valid}, 64'h1);
      step(1, 0, 0, 0, 64'h0);
      chk("mid_rst_addr", Inst_address, 64'h0);
      chk("mid_rst_valid", {63'h0, if_id_valid}, 64'h0);
      chk("mid_rst_count", {32'h0, fetch_count}, 64'h0);
      chk("mid_rst_instr", {32'h0, if_id_instr}, 64'h13);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. Holds the PC and drives Inst_address to the combinational instruction memory. Samples the returned Instruction into the IF/ID pipeline register and handles stall, flush, branch redirect, end-of-program halt and misaligned targets. Sits between the hazard/branch logic and the decode stage of the pipelined RV64 core.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
MEM_BYTES, 160, byte size of the instruction memory. The last legal fetch address is MEM_BYTES-4.
XLEN, 64, PC/address width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold PC and IF/ID contents (load-use hazard)
flush  in  1  replace the IF/ID contents with a bubble this cycle
redirect_valid  in  1  branch/jump taken, resolved in EX
redirect_target  in  XLEN  new PC when redirect_valid=1
Inst_address  out  XLEN  byte address to the instruction memory; equals pc_q combinationally
Instruction  in  32  little-endian word returned by the memory in the same cycle
if_id_valid  out  1  IF/ID holds a real instruction
if_id_pc  out  XLEN  PC of the IF/ID instruction
if_id_instr  out  32  IF/ID instruction; NOP when not valid
halted  out  1  fetch stopped (end of program or error)
misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0
fetch_count  out  32  number of valid instructions delivered to IF/ID

Behaviour:
- Reset values: pc_q=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_instr=NOP (32'h00000013), halted=0, misalign_err=0, fetch_count=0. Reset mid-operation discards all state in one cycle.
- Read latency is 0: the memory is combinational. Instruction is sampled at the same edge that advances the PC. Each accepted fetch is 1 cycle.
- Per-edge priority is reset > redirect > stall > halted > normal.
- Redirect, aligned target: pc_q<=target, halted<=0, IF/ID<=bubble. Redirect wins over a simultaneous stall or flush.
- Redirect, misaligned target: pc_q holds, misalign_err<=1, halted<=1, IF/ID<=bubble. Only reset clears misalign_err. A later aligned redirect clears halted but not misalign_err.
- Stall without redirect: pc_q, IF/ID and fetch_count all hold.
- Stall together with flush: pc_q holds and IF/ID<=bubble.
- Halted, no redirect, no stall: pc_q holds and IF/ID<=bubble.
- Normal case: if_id_instr<=Instruction, if_id_pc<=pc_q, if_id_valid<=1, fetch_count+=1, pc_q<=pc_q+4.
- Flush without stall or redirect: IF/ID<=bubble, pc_q still advances by 4, and the fetched word is dropped (no count).
- End of program: in the normal case, if Instruction==32'h0 or pc_q>MEM_BYTES-4, then halted<=1, IF/ID<=bubble and pc_q holds. This is not an error. A later redirect restarts fetch, which covers a backward branch still in flight.
- Bubble means if_id_valid=0, if_id_instr=NOP, if_id_pc=0.
- PC arithmetic is XLEN-bit modulo. fetch_count wraps at 2^32.

Decomposition:
- Shared package rv_fetch_pkg holds: NOP_INSTR=32'h00000013, HALT_WORD=32'h0, XLEN, and the typedef if_id_t {valid, pc, instr}.
- One natural sub-module: if_id_reg, the IF/ID register with stall/flush/bubble. The PC and halt control stay in the top module.

Test Plan:
- Reset, then 4 free-running cycles with memory words 00210493, 00518233, 00000413, 00050513 -> if_id_pc goes 0, 4, 8, C; if_id_instr matches each word; fetch_count=4.
- Assert stall for 2 cycles at pc_q=8 -> Inst_address stays 8, IF/ID holds 00518233/pc 4, fetch_count is unchanged. Release -> fetch resumes at 8.
- redirect_valid=1 with target 0x40 while stall=1 -> next cycle pc_q=0x40 and if_id_valid=0. The following cycle if_id_pc=0x40.
- redirect_target=0x42 -> misalign_err=1, halted=1, bubbles issued. Then redirect to 0x10 -> halted=0, misalign_err stays 1, fetch resumes at 0x10.
- Run to pc_q=0x90 where the word is 0 -> halted=1, pc_q holds at 0x90, bubbles issued. Redirect to 0x24 -> fetch resumes. Also check pc_q=0xA0 (>MEM_BYTES-4) -> halted.
- Assert reset while pc_q=0x30 and if_id_valid=1 -> after one edge all outputs take their reset values and Inst_address=0.
